// File: rtl/clk_enable_gen.sv
// Core reset and clock-enable generator for the Prehistoric Isle core.
// Filters PLL lock into core_rst_n and derives all clk_sys-qualified enables.
module clk_enable_gen #(
    parameter int CPU_DIV   = 8,
    parameter int PIX_DIV   = 12,
    parameter int SND_DIV   = 18,
    parameter int ADPCM_NUM = 4,
    parameter int ADPCM_DEN = 450,
    parameter int LOCK_HOLD = 4096
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic pause,
    output logic core_rst_n,
    output logic ce_cpu,
    output logic ce_cpu_n,
    output logic ce_pix,
    output logic ce_snd,
    output logic ce_adpcm
);

    localparam int CPU_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int SND_W = (SND_DIV > 1) ? $clog2(SND_DIV) : 1;
    localparam int ACC_W = (ADPCM_DEN > 1) ? $clog2(ADPCM_DEN) : 1;

    localparam logic [CPU_W-1:0] CPU_LAST = CPU_W'(CPU_DIV - 1);
    localparam logic [CPU_W-1:0] CPU_HALF = CPU_W'(CPU_DIV / 2);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);
    localparam logic [SND_W-1:0] SND_LAST = SND_W'(SND_DIV - 1);
    localparam logic [ACC_W:0]   ACC_NUM  = (ACC_W + 1)'(ADPCM_NUM);
    localparam logic [ACC_W:0]   ACC_DEN  = (ACC_W + 1)'(ADPCM_DEN);
    localparam logic [ACC_W:0]   ACC_THR  = (ACC_W + 1)'(ADPCM_DEN - ADPCM_NUM);
    localparam logic [12:0]      LK_HOLD  = 13'(LOCK_HOLD);

    logic             lk_meta;
    logic             lk_s;
    logic [12:0]      lk_cnt;
    logic [CPU_W-1:0] cpu_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [SND_W-1:0] snd_cnt;
    logic [ACC_W-1:0] acc;

    logic             run_d;
    logic             active;
    logic [12:0]      lk_cnt_nxt;
    logic [CPU_W-1:0] cpu_nxt;
    logic [PIX_W-1:0] pix_nxt;
    logic [SND_W-1:0] snd_nxt;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W:0]   acc_nxt;

    // Enables are registered from the counters' next values, so a pulse
    // appears in the same cycle its counter sits at the trigger value.
    always_comb begin
        run_d      = lk_s && (lk_cnt == LK_HOLD);
        active     = run_d && core_rst_n;
        lk_cnt_nxt = '0;
        cpu_nxt    = '0;
        pix_nxt    = '0;
        snd_nxt    = '0;
        acc_sum    = {1'b0, acc} + ACC_NUM;
        acc_nxt    = '0;

        if (lk_s) begin
            lk_cnt_nxt = (lk_cnt < LK_HOLD) ? lk_cnt + 13'd1 : lk_cnt;
        end

        if (active) begin
            cpu_nxt = (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + CPU_W'(1);
            pix_nxt = (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PIX_W'(1);
            snd_nxt = (snd_cnt == SND_LAST) ? '0 : snd_cnt + SND_W'(1);
            acc_nxt = ({1'b0, acc} >= ACC_THR) ? acc_sum - ACC_DEN : acc_sum;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            lk_meta    <= 1'b0;
            lk_s       <= 1'b0;
            lk_cnt     <= '0;
            core_rst_n <= 1'b0;
            cpu_cnt    <= '0;
            pix_cnt    <= '0;
            snd_cnt    <= '0;
            acc        <= '0;
            ce_cpu     <= 1'b0;
            ce_cpu_n   <= 1'b0;
            ce_pix     <= 1'b0;
            ce_snd     <= 1'b0;
            ce_adpcm   <= 1'b0;
        end else begin
            lk_meta    <= pll_locked;
            lk_s       <= lk_meta;
            lk_cnt     <= lk_cnt_nxt;
            core_rst_n <= run_d;
            cpu_cnt    <= cpu_nxt;
            pix_cnt    <= pix_nxt;
            snd_cnt    <= snd_nxt;
            acc        <= acc_nxt[ACC_W-1:0];
            // Pause gates only the outputs; counters keep phase.
            ce_cpu     <= run_d && !pause && (cpu_nxt == '0);
            ce_cpu_n   <= run_d && !pause && (cpu_nxt == CPU_HALF);
            ce_pix     <= run_d && (pix_nxt == '0);
            ce_snd     <= run_d && !pause && (snd_nxt == '0);
            ce_adpcm   <= run_d && !pause && (acc_nxt >= ACC_THR);
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: lock release, enable phasing, pause,
// lock glitch and reset during the lock hold.
module tb_clk_enable_gen;

    logic clk_sys = 1'b0;
    logic reset_n;
    logic pll_locked;
    logic pause;
    logic core_rst_n;
    logic ce_cpu;
    logic ce_cpu_n;
    logic ce_pix;
    logic ce_snd;
    logic ce_adpcm;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    clk_enable_gen dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .pause      (pause),
        .core_rst_n (core_rst_n),
        .ce_cpu     (ce_cpu),
        .ce_cpu_n   (ce_cpu_n),
        .ce_pix     (ce_pix),
        .ce_snd     (ce_snd),
        .ce_adpcm   (ce_adpcm)
    );

    always #5 clk_sys = ~clk_sys;

    // Cycle n is the interval after the n-th rising edge; sampled 1 ns in.
    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [4:0] ces();
        return {ce_cpu, ce_cpu_n, ce_pix, ce_snd, ce_adpcm};
    endfunction

    // Expected {cpu, cpu_n, pix, snd, adpcm} k cycles after release.
    function automatic logic [4:0] model(input int k, input bit p);
        logic [4:0] v;
        v[4] = (k % 8 == 0) && !p;
        v[3] = (k % 8 == 4) && !p;
        v[2] = (k % 12 == 0);
        v[1] = (k % 18 == 0) && !p;
        v[0] = (((4 * k) % 450) >= 446) && !p;
        return v;
    endfunction

    initial begin
        int r, f, g, x, bad;
        int c_cpu, c_cpun, c_pix, c_snd, c_adp, gap_bad, ibad;
        int last_cpu, last_adp, first_adp, p_quiet, p_pix, first_cpu_after;
        bit p;
        logic [4:0] v;

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        pause      = 1'b0;

        // Reset and lock release
        repeat (4) step();
        chk("reset_outputs", {26'd0, core_rst_n, ces()}, 32'd0);
        reset_n = 1'b1;
        while (cyc < 10) step();
        pll_locked = 1'b1;
        bad = 0;
        while (cyc < 4108) begin
            step();
            if (core_rst_n || (ces() != 5'd0)) bad++;
        end
        chk("hold_quiet", bad, 0);
        step();
        chk("release_cycle_4109", {31'd0, core_rst_n}, 1);
        chk("release_enables", {27'd0, ces()}, 32'b10110);
        r = cyc;

        // Free run with a pause window at R+22601..R+22800
        c_cpu = 0; c_cpun = 0; c_pix = 0; c_snd = 0; c_adp = 0;
        gap_bad = 0; ibad = 0; last_cpu = -100; last_adp = -1; first_adp = -1;
        p_quiet = 0; p_pix = 0; first_cpu_after = -1;
        for (int k = 0; k < 23500; k++) begin
            p = (k >= 22601) && (k <= 22800);
            v = ces();
            chk("run_pattern", {27'd0, v}, {27'd0, model(k, p)});
            if (k < 720) begin
                c_cpu  += int'(v[4]);
                c_cpun += int'(v[3]);
                c_pix  += int'(v[2]);
                c_snd  += int'(v[1]);
                if (v[3] && (k - last_cpu != 4)) gap_bad++;
            end
            if (v[4]) last_cpu = k;
            if ((k < 22500) && v[0]) begin
                c_adp++;
                if (last_adp < 0) first_adp = k;
                else if ((k - last_adp != 112) && (k - last_adp != 113)) ibad++;
                last_adp = k;
            end
            if (p) begin
                if (v[4] || v[3] || v[1] || v[0]) p_quiet++;
                p_pix += int'(v[2]);
            end
            if ((k > 22800) && v[4] && (first_cpu_after < 0)) first_cpu_after = k;
            if (k == 22600) pause = 1'b1;
            if (k == 22800) pause = 1'b0;
            step();
        end
        chk("cpu_count_720", c_cpu, 90);
        chk("cpu_n_count_720", c_cpun, 90);
        chk("pix_count_720", c_pix, 60);
        chk("snd_count_720", c_snd, 40);
        chk("cpu_n_gap_4", gap_bad, 0);
        chk("adpcm_count_22500", c_adp, 200);
        chk("adpcm_first_112", first_adp, 112);
        chk("adpcm_interval", ibad, 0);
        chk("pause_quiet", p_quiet, 0);
        chk("pause_pix_live", p_pix, 17);
        chk("cpu_after_pause", first_cpu_after, 22808);

        // One-cycle lock glitch during run
        f = cyc;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        chk("glitch_still_up_f2", {31'd0, core_rst_n}, 1);
        step();
        chk("glitch_down_f3", {31'd0, core_rst_n}, 0);
        chk("glitch_ces_f3", {27'd0, ces()}, 0);
        bad = 0;
        while (cyc < f + 4099) begin
            step();
            if (core_rst_n || (ces() != 5'd0)) bad++;
        end
        chk("glitch_full_hold", bad, 0);
        step();
        chk("glitch_release", {31'd0, core_rst_n}, 1);
        r = cyc;
        for (int k = 0; k < 120; k++) begin
            chk("rerun_pattern", {27'd0, ces()}, {27'd0, model(k, 1'b0)});
            step();
        end

        // reset_n asserted at lock-hold count 2000
        g = cyc;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        while (cyc < g + 2003) step();
        chk("hold_count_2000", {19'd0, dut.lk_cnt}, 2000);
        reset_n = 1'b0;
        step();
        chk("midhold_lk_cnt", {19'd0, dut.lk_cnt}, 0);
        chk("midhold_outputs", {26'd0, core_rst_n, ces()}, 0);
        repeat (2) step();
        reset_n = 1'b1;
        x = cyc;
        while (cyc < x + 4098) step();
        chk("rehold_not_early", {31'd0, core_rst_n}, 0);
        step();
        chk("rehold_release", {31'd0, core_rst_n}, 1);
        chk("rehold_enables", {27'd0, ces()}, 32'b10110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
